// File: rtl/hog_buf_pkg.sv
// Shared types and sizing for the HOG cell-feature buffer window sequencer.
package hog_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_IMG_W = 80;
  localparam int DEF_IMG_H = 60;
  localparam int DEF_WIN_W = 8;
  localparam int DEF_WIN_H = 16;

  // Counter width for a range of n values; a one-element range still needs a bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int COL_W = cnt_w(DEF_IMG_W);
  localparam int ROW_W = cnt_w(DEF_IMG_H);

endpackage

// File: rtl/buffer_window_ctrl_if.sv
// Frame control, cell stream and window handshake between the sequencer and its neighbours.
interface buffer_window_ctrl_if #(
  parameter int XW = hog_buf_pkg::COL_W,
  parameter int YW = hog_buf_pkg::ROW_W
);
  logic          i_start;
  logic          i_valid;
  logic          o_ready;
  logic          o_shift;
  logic          o_win_valid;
  logic          i_win_ready;
  logic [XW-1:0] o_win_x;
  logic [YW-1:0] o_win_y;
  logic          o_busy;
  logic          o_frame_done;

  modport slave (
    input  i_start, i_valid, i_win_ready,
    output o_ready, o_shift, o_win_valid, o_win_x, o_win_y, o_busy, o_frame_done
  );

  modport master (
    output i_start, i_valid, i_win_ready,
    input  o_ready, o_shift, o_win_valid, o_win_x, o_win_y, o_busy, o_frame_done
  );
endinterface

// File: rtl/raster_pos_counter.sv
// Raster position (col, row) of the next incoming cell, with a flag for the last cell of a frame.
module raster_pos_counter
  import hog_buf_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int CW    = COL_W,
   parameter int RW    = ROW_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          last
);

   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

   logic col_end;

   assign col_end = (col == COL_MAX);
   assign last    = col_end && (row == ROW_MAX);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (inc && !last) begin
         if (col_end) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/buffer_window_ctrl.sv
// Sequencer for the buffer_element shift chain: gates shifts, tracks raster position and presents complete windows.
module buffer_window_ctrl
  import hog_buf_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int WIN_W = DEF_WIN_W,
   parameter int WIN_H = DEF_WIN_H
) (
   input  logic                clk,
   input  logic                rst,
   buffer_window_ctrl_if.slave bus
);

   localparam int CW = cnt_w(IMG_W);
   localparam int RW = cnt_w(IMG_H);
   localparam logic [CW-1:0] X_OFF = CW'(WIN_W - 1);
   localparam logic [RW-1:0] Y_OFF = RW'(WIN_H - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] col, win_x_q;
   logic [RW-1:0] row, win_y_q;
   logic          last_cell;
   logic          win_valid_q, frame_done_q, busy_q;
   logic          ready, shift, qualify, start_frame;

   // Stall while a window is presented and not yet taken, so the chain stays frozen under it.
   assign ready       = (state_q == RUN) && (!win_valid_q || bus.i_win_ready);
   assign shift       = bus.i_valid && ready;
   assign start_frame = (state_q == IDLE) && bus.i_start;
   assign qualify     = shift && (col >= X_OFF) && (row >= Y_OFF);

   raster_pos_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .CW    (CW),
      .RW    (RW)
   ) u_pos (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_frame),
      .inc  (shift),
      .col  (col),
      .row  (row),
      .last (last_cell)
   );

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: next state defaults to the current state before the case, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.i_start) state_d = RUN;
         RUN:     if (shift && last_cell) state_d = FLUSH;
         FLUSH:   if (!win_valid_q || bus.i_win_ready) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A new qualifying shift overrides the clear from an acceptance in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         win_valid_q <= 1'b0;
         win_x_q     <= '0;
         win_y_q     <= '0;
      end else if (qualify) begin
         win_valid_q <= 1'b1;
         win_x_q     <= col - X_OFF;
         win_y_q     <= row - Y_OFF;
      end else if (bus.i_win_ready) begin
         win_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         frame_done_q <= (state_d == DONE);
         busy_q       <= (state_d != IDLE);
      end
   end

   assign bus.o_ready      = ready;
   assign bus.o_shift      = shift;
   assign bus.o_win_valid  = win_valid_q;
   assign bus.o_win_x      = win_x_q;
   assign bus.o_win_y      = win_y_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_frame_done = frame_done_q;

endmodule

// File: tb/tb_buffer_window_ctrl.sv
// Scoreboard bench for buffer_window_ctrl: a 4x3 image with 2x2 windows, plus a 2x1 degenerate instance.
module tb_buffer_window_ctrl;
  import hog_buf_pkg::*;

  localparam int AW = 4, AH = 3, AWW = 2, AWH = 2;
  localparam int BW = 2, BH = 1, BWW = 2, BWH = 1;

  typedef struct { int x; int y; } coord_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  buffer_window_ctrl_if #(.XW(cnt_w(AW)), .YW(cnt_w(AH))) bus_a ();
  buffer_window_ctrl_if #(.XW(cnt_w(BW)), .YW(cnt_w(BH))) bus_b ();

  buffer_window_ctrl #(.IMG_W(AW), .IMG_H(AH), .WIN_W(AWW), .WIN_H(AWH)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a)
  );
  buffer_window_ctrl #(.IMG_W(BW), .IMG_H(BH), .WIN_W(BWW), .WIN_H(BWH)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;
  int shift_cnt_a = 0, done_cnt_a = 0, shift_cnt_b = 0, done_cnt_b = 0;
  coord_t exp_a[$];
  coord_t exp_b[$];
  coord_t ea, eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: count shifts/done pulses and compare every accepted window with the queue head.
  always @(negedge clk) begin
    if (rst_a) begin
      if (bus_a.o_shift) shift_cnt_a++;
      if (bus_a.o_frame_done) done_cnt_a++;
      if (bus_a.o_win_valid && bus_a.i_win_ready) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL win_a_extra: got (%0d,%0d) expected no window", bus_a.o_win_x, bus_a.o_win_y);
        end else begin
          ea = exp_a.pop_front();
          check("win_a_x", 32'(bus_a.o_win_x), ea.x);
          check("win_a_y", 32'(bus_a.o_win_y), ea.y);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      if (bus_b.o_shift) shift_cnt_b++;
      if (bus_b.o_frame_done) done_cnt_b++;
      if (bus_b.o_win_valid && bus_b.i_win_ready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL win_b_extra: got (%0d,%0d) expected no window", bus_b.o_win_x, bus_b.o_win_y);
        end else begin
          eb = exp_b.pop_front();
          check("win_b_x", 32'(bus_b.o_win_x), eb.x);
          check("win_b_y", 32'(bus_b.o_win_y), eb.y);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_frame_a();
    coord_t c;
    for (int y = 0; y <= AH - AWH; y++)
      for (int x = 0; x <= AW - AWW; x++) begin
        c.x = x; c.y = y;
        exp_a.push_back(c);
      end
  endtask

  task automatic start_a();
    bus_a.i_start = 1'b1; bus_a.i_valid = 1'b0; bus_a.i_win_ready = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    check("start_a_busy", 32'(bus_a.o_busy), 1);
  endtask

  // Drive valid (continuous or every other cycle) with ready high until n more shifts are seen.
  task automatic shift_a(input int n, input bit bubbles);
    int target, budget;
    bit ph;
    target = shift_cnt_a + n; budget = 200; ph = 1'b0;
    while (shift_cnt_a < target && budget > 0) begin
      bus_a.i_valid = bubbles ? ph : 1'b1;
      bus_a.i_win_ready = 1'b1;
      ph = ~ph;
      tick();
      budget--;
    end
    bus_a.i_valid = 1'b0;
    check("shifts_reached_a", shift_cnt_a, target);
  endtask

  task automatic wait_done_a();
    int d0, n;
    d0 = done_cnt_a; n = 0;
    while (done_cnt_a == d0 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    check("frame_done_count_a", done_cnt_a - d0, 1);
  endtask

  task automatic check_reset_a();
    check("rst_a_ready", 32'(bus_a.o_ready), 0);
    check("rst_a_shift", 32'(bus_a.o_shift), 0);
    check("rst_a_win_valid", 32'(bus_a.o_win_valid), 0);
    check("rst_a_busy", 32'(bus_a.o_busy), 0);
    check("rst_a_frame_done", 32'(bus_a.o_frame_done), 0);
    check("rst_a_win_x", 32'(bus_a.o_win_x), 0);
    check("rst_a_win_y", 32'(bus_a.o_win_y), 0);
  endtask

  initial begin
    int s0, d0;
    coord_t c;
    bus_a.i_start = 1'b0; bus_a.i_valid = 1'b1; bus_a.i_win_ready = 1'b1;
    bus_b.i_start = 1'b0; bus_b.i_valid = 1'b1; bus_b.i_win_ready = 1'b1;
    repeat (3) tick();
    check_reset_a();
    check("rst_b_busy", 32'(bus_b.o_busy), 0);
    check("rst_b_ready", 32'(bus_b.o_ready), 0);
    bus_a.i_valid = 1'b0;
    rst_a = 1'b1;
    tick();

    // 1: full frame, continuous valid, first window right after shift 6
    push_frame_a();
    s0 = shift_cnt_a; d0 = done_cnt_a;
    start_a();
    shift_a(5, 1'b0);
    check("t1_no_win_after_5", 32'(bus_a.o_win_valid), 0);
    shift_a(1, 1'b0);
    check("t1_win_after_6", 32'(bus_a.o_win_valid), 1);
    shift_a(6, 1'b0);
    check("t1_done_not_yet", 32'(bus_a.o_frame_done), 0);
    tick();
    check("t1_done_pulse", 32'(bus_a.o_frame_done), 1);
    tick();
    check("t1_done_low", 32'(bus_a.o_frame_done), 0);
    check("t1_idle", 32'(bus_a.o_busy), 0);
    repeat (3) tick();
    check("t1_shift_total", shift_cnt_a - s0, 12);
    check("t1_done_total", done_cnt_a - d0, 1);
    check("t1_queue_empty", exp_a.size(), 0);

    // 2: stall at the first window, then release
    push_frame_a();
    start_a();
    shift_a(6, 1'b0);
    bus_a.i_win_ready = 1'b0; bus_a.i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_ready_low", 32'(bus_a.o_ready), 0);
      check("t2_shift_low", 32'(bus_a.o_shift), 0);
      check("t2_x_stable", 32'(bus_a.o_win_x), 0);
      check("t2_y_stable", 32'(bus_a.o_win_y), 0);
      tick();
    end
    bus_a.i_win_ready = 1'b1;
    #1;
    check("t2_resume_shift", 32'(bus_a.o_shift), 1);
    tick();

    // 3: last window held unaccepted in FLUSH
    shift_a(5, 1'b0);
    bus_a.i_win_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_busy", 32'(bus_a.o_busy), 1);
      check("t3_done_withheld", 32'(bus_a.o_frame_done), 0);
      check("t3_last_x", 32'(bus_a.o_win_x), 2);
      check("t3_last_y", 32'(bus_a.o_win_y), 1);
      tick();
    end
    bus_a.i_win_ready = 1'b1;
    tick();
    check("t3_done_pulse", 32'(bus_a.o_frame_done), 1);
    tick();
    check("t3_done_low", 32'(bus_a.o_frame_done), 0);
    check("t3_queue_empty", exp_a.size(), 0);

    // 4: valid every other cycle
    push_frame_a();
    s0 = shift_cnt_a;
    start_a();
    shift_a(12, 1'b1);
    wait_done_a();
    check("t4_shift_total", shift_cnt_a - s0, 12);
    check("t4_queue_empty", exp_a.size(), 0);

    // 5: reset after shift 7 abandons the frame
    c.x = 0; c.y = 0;
    exp_a.push_back(c);
    d0 = done_cnt_a;
    start_a();
    shift_a(7, 1'b0);
    rst_a = 1'b0; bus_a.i_valid = 1'b1;
    repeat (2) tick();
    check_reset_a();
    rst_a = 1'b1;
    tick();
    check("t5_valid_ignored_idle", 32'(bus_a.o_shift), 0);
    repeat (3) tick();
    bus_a.i_valid = 1'b0;
    check("t5_no_done", done_cnt_a - d0, 0);
    check("t5_queue_empty", exp_a.size(), 0);
    push_frame_a();
    start_a();
    shift_a(12, 1'b0);
    wait_done_a();
    check("t5_new_frame_queue_empty", exp_a.size(), 0);

    // 6: 2x1 image, one window, i_start during RUN ignored
    bus_b.i_valid = 1'b0;
    rst_b = 1'b1;
    tick();
    c.x = 0; c.y = 0;
    exp_b.push_back(c);
    bus_b.i_start = 1'b1;
    tick();
    bus_b.i_start = 1'b0; bus_b.i_valid = 1'b1;
    tick();
    bus_b.i_start = 1'b1; bus_b.i_valid = 1'b0;
    #1;
    check("t6_busy_in_run", 32'(bus_b.o_busy), 1);
    check("t6_ready_in_run", 32'(bus_b.o_ready), 1);
    tick();
    bus_b.i_start = 1'b0; bus_b.i_valid = 1'b1;
    tick();
    bus_b.i_valid = 1'b0;
    check("t6_win_valid", 32'(bus_b.o_win_valid), 1);
    check("t6_flush_not_ready", 32'(bus_b.o_ready), 0);
    tick();
    check("t6_done_pulse", 32'(bus_b.o_frame_done), 1);
    tick();
    check("t6_idle", 32'(bus_b.o_busy), 0);
    check("t6_shift_total", shift_cnt_b, 2);
    check("t6_done_total", done_cnt_b, 1);
    check("t6_queue_empty", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
